// File: rtl/multi_timer_pkg.sv
// Shared encodings for the multi-channel timer: channel state and load mode.
package multi_timer_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PERIODIC = 2'd1,
    ONESHOT  = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: period register, down-counter and IDLE/PERIODIC/ONESHOT state.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] m,
  input  logic             ld_mode,
  input  logic             en,
  input  logic             clr_done,
  output logic             tick,
  output logic             done,
  output logic             busy
);
  state_e           st_q, st_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] m_m1;

  assign tick = (st_q != IDLE) && (cnt_q == '0);
  assign busy = (st_q != IDLE);
  assign done = done_q;
  // M=0 behaves like M=1: both give a terminal count of zero.
  assign m_m1 = (m == '0) ? '0 : m - WIDTH'(1);

  always_comb begin
    st_d   = st_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (ld) begin
      per_d  = m_m1;
      cnt_d  = m_m1;
      st_d   = (ld_mode == MODE_ONESHOT) ? ONESHOT : PERIODIC;
      done_d = 1'b0;
    end else begin
      if (clr_done) done_d = 1'b0;
      case (st_q)
        PERIODIC: begin
          if (tick)    cnt_d = per_q;
          else if (en) cnt_d = cnt_q - WIDTH'(1);
        end
        ONESHOT: begin
          // Completion set is evaluated after clr_done so it wins.
          if (tick) begin
            st_d   = IDLE;
            done_d = 1'b1;
          end else if (en) begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      per_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/multi_timer.sv
// NCH independent programmable timers sharing one load port.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SELW-1:0]  load_sel,
  input  logic [WIDTH-1:0] M,
  input  logic             mode,
  input  logic [NCH-1:0]   enable,
  input  logic [NCH-1:0]   clr_done,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   busy
);
  logic [NCH-1:0] ld;

  // Out-of-range selects match no channel and are dropped.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ld[k] = load && (load_sel == SELW'(k));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .ld       (ld[k]),
      .m        (M),
      .ld_mode  (mode),
      .en       (enable[k]),
      .clr_done (clr_done[k]),
      .tick     (tick[k]),
      .done     (done[k]),
      .busy     (busy[k])
    );
  end
endmodule
